seq_adder: RTL and testbench
============================

Name: seq_adder

Overview:
- Multi-cycle, parametrised two's-complement adder/subtractor.
- Processes DIGIT bits per clock through a combinational digit adder and holds the carry in a register between digits.
- Generalises the single-bit full-adder cell to WIDTH-bit operands, with add/sub mode, signed-overflow detection and valid/ready handshakes on input and output.
- Sits in the arithmetic datapath as the area-cheap alternative to a wide ripple adder.

Parameters:
- WIDTH, 16, operand and result width in bits; WIDTH >= 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly.
- NDIG, WIDTH/DIGIT, derived localparam, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start_valid  input  1  operands and mode on a/b/cin/sub are valid.
- start_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = A+B+cin; 1 = A-B-cin.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry-out (add) / not-borrow (sub).
- ovf  output  1  signed overflow.
- done_valid  output  1  sum/cout/ovf are valid.
- done_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, sum=0, cout=0, ovf=0, done_valid=0, digit counter=0, carry reg=0.
  - start_ready=1 in the first cycle after rst deasserts.
  - Reset mid-RUN or mid-DONE aborts the operation immediately; the partial result is discarded.
- States:
  - IDLE: start_ready=1, done_valid=0.
    - start_valid=1 at edge E0 -> capture a, b_eff = b XOR {WIDTH{sub}}, carry = cin XOR sub, cnt=0.
    - Next state RUN.
  - RUN: start_ready=0, done_valid=0.
    - Each edge: digit cnt of a and b_eff plus carry -> DIGIT sum bits written into sum[cnt*DIGIT +: DIGIT]; carry reg updated.
    - cnt increments each edge.
    - At edge EN (cnt==NDIG-1): cout = final carry; ovf = carry into MSB XOR carry out of MSB. Next state DONE.
  - DONE: done_valid=1; sum/cout/ovf held stable.
    - done_ready=1 -> IDLE at that edge.
    - done_ready=0 -> remain in DONE indefinitely.
- Latency: done_valid rises after edge E_NDIG, i.e. NDIG+1 edges after acceptance (default 4 RUN cycles).
- Throughput: one operation per NDIG+2 cycles.
- start_ready=1 only in IDLE. start_valid outside IDLE is ignored; the upstream holds it.
- Inputs a/b/cin/sub are sampled only at acceptance; later changes have no effect on the running operation.
- Arithmetic is modulo 2^WIDTH.
  - Sub mode: cout=1 means no borrow (A >= B+cin unsigned).
  - ovf is valid for both modes under signed interpretation.
- sum bits not yet computed during RUN are don't-care externally; done_valid gates all use.
- DIGIT==WIDTH (NDIG=1) is legal: one RUN cycle.

Decomposition:
- Shared include seq_adder_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - the DIGIT-divides-WIDTH check macro.
- One natural sub-module: digit_adder.
  - Combinational, DIGIT-bit ripple chain of full-adder cells.
  - Outputs: s[DIGIT-1:0], c_out, and c_msb (carry into the top bit, used for ovf).
- Counter width is clog2(NDIG), minimum 1.

Test Plan (WIDTH=16, DIGIT=4):
- Add 0xFFFF + 0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0; done_valid exactly 5 edges after acceptance.
- Add 0x7FFF + 0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Add 0x1234 + 0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- Sub 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: done_ready held 0 for 6 cycles -> done_valid stays 1, sum stable, start_ready=0; a new start_valid is ignored. Then done_ready=1 -> IDLE next edge, start_ready=1.
- Operand change: a/b toggled every cycle during RUN -> result equals the operands captured at E0.
- Async reset asserted mid-RUN (after 2 digits) -> all outputs 0 immediately, without waiting for a clock edge. After release, a fresh 0x0003+0x0004 -> sum=0x0007.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared types and helpers for the digit-serial adder.
//   state_e        FSM state encoding (IDLE / RUN / DONE)
//   cnt_width()    width of the digit counter, never less than 1 bit
package seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-digit configuration still needs a 1-bit counter to exist.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/seq_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple chain of full-adder cells.
//   a_i, b_i   DIGIT-bit operand digits
//   c_i        carry into bit 0
//   s_o        DIGIT-bit sum digit
//   c_out_o    carry out of the top bit
//   c_msb_o    carry into the top bit (XOR with c_out_o gives signed overflow)
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_out_o,
    output logic             c_msb_o
);

    logic [DIGIT:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_out_o = c[DIGIT];
    assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/seq_adder.sv
// seq_adder: multi-cycle two's-complement adder/subtractor, DIGIT bits per clock.
//   clk, rst                 clock, asynchronous active-high reset
//   start_valid/start_ready  operand handshake (a, b, cin, sub sampled on acceptance)
//   a, b                     WIDTH-bit operands
//   cin                      carry-in (add) / borrow-in (sub)
//   sub                      0: a+b+cin, 1: a-b-cin
//   sum, cout, ovf           registered result, carry/not-borrow, signed overflow
//   done_valid/done_ready    result handshake; result held until accepted
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(NDIG);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
        $error("seq_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cout_q, ovf_q, done_valid_q;

    logic [DIGIT-1:0] a_dig, b_dig, s_dig;
    logic             c_out, c_msb;

    assign a_dig = a_q[cnt_q*DIGIT +: DIGIT];
    assign b_dig = b_q[cnt_q*DIGIT +: DIGIT];

    digit_adder #(.DIGIT(DIGIT)) u_dig (
        .a_i     (a_dig),
        .b_i     (b_dig),
        .c_i     (carry_q),
        .s_o     (s_dig),
        .c_out_o (c_out),
        .c_msb_o (c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        // Subtraction as a + ~b + 1; borrow-in folds into the same carry.
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= cin ^ sub;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[cnt_q*DIGIT +: DIGIT] <= s_dig;
                    carry_q <= c_out;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cout_q       <= c_out;
                        ovf_q        <= c_msb ^ c_out;
                        done_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        done_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    done_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign done_valid  = done_valid_q;

endmodule

// File: tb/tb_seq_adder.sv
module tb_seq_adder;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf;
    logic             done_valid;
    logic             done_ready;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    seq_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completed result handshake.
    always @(negedge clk) begin
        if (!rst && done_valid && done_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'(sum), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sum",  32'(sum),  32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("ovf",  32'(ovf),  32'(e.ovf));
            end
        end
    end

    // Waits for start_ready, presents the operands, returns just after acceptance edge.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tcin, input logic tsub,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int n = 0;
        exp_t e;
        while (!start_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("start_ready_timeout", 32'(start_ready), 32'd1);
        a = ta; b = tb; cin = tcin; sub = tsub; start_valid = 1'b1;
        @(posedge clk);
        e.sum = es; e.cout = ec; e.ovf = eo;
        sb_q.push_back(e);
        #1 start_valid = 1'b0;
    endtask

    // Counts edges from acceptance (inclusive) until done_valid appears.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!done_valid) chk("done_timeout", 32'(done_valid), 32'd1);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a, b;
        logic cin, sub;
        logic [WIDTH-1:0] s;
        logic c, o;
    } vec_t;

    initial begin
        int lat;
        logic [WIDTH-1:0] held;
        vec_t vecs[6];

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};

        rst = 1'b1; start_valid = 1'b0; done_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_sum",        32'(sum),        32'd0);
        chk("rst_cout",       32'(cout),       32'd0);
        chk("rst_ovf",        32'(ovf),        32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("start_ready_after_rst", 32'(start_ready), 32'd1);

        // Directed vectors; first one also checks latency.
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].c, vecs[i].o);
            wait_done(lat);
            if (i == 0) chk("latency_edges", 32'(lat), 32'd5);
            @(posedge clk); #1;
        end

        // Backpressure: result held, new start ignored while in DONE.
        done_ready = 1'b0;
        issue(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        wait_done(lat);
        held = sum;
        a = 16'h1111; b = 16'h2222; start_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("bp_done_valid",  32'(done_valid),  32'd1);
            chk("bp_sum_stable",  32'(sum),         32'(held));
            chk("bp_start_ready", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_start_ready", 32'(start_ready), 32'd1);
        chk("bp_release_done_valid",  32'(done_valid),  32'd0);

        // Operands wiggle during RUN; result must reflect the captured ones.
        issue(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            a = 16'($urandom); b = 16'($urandom); cin = ~cin; sub = ~sub;
            @(posedge clk); #1;
        end
        wait_done(lat);
        @(posedge clk); #1;

        // Asynchronous reset two digits into RUN.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_sum",        32'(sum),        32'd0);
        chk("arst_cout",       32'(cout),       32'd0);
        chk("arst_ovf",        32'(ovf),        32'd0);
        chk("arst_done_valid", 32'(done_valid), 32'd0);
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        issue(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        wait_done(lat);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
